// File: rtl/ps2_receiver.sv
`default_nettype none
// ------------------------------------------------------------------
// ps2_receiver: filtered PS/2 frame receiver feeding a byte FIFO
// Rev 1.0
// ------------------------------------------------------------------
module ps2_receiver #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 20000,
  parameter int FIFO_LOG2  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       parity_error,
  output logic       frame_error,
  output logic       overflow
);

  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam int TW    = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // index 0 is the PS/2 clock line, index 1 the data line
  logic [1:0] raw;
  logic [1:0] sync1, sync2, filt;
  logic [7:0] fcnt [2];
  logic       clk_prev;
  logic       fall;
  logic       din;

  assign raw  = {ps2_data_in, ps2_clk_in};
  assign fall = clk_prev & ~filt[0];
  assign din  = filt[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= 2'b11;
      sync2    <= 2'b11;
      filt     <= 2'b11;
      clk_prev <= 1'b1;
      for (int i = 0; i < 2; i++) fcnt[i] <= 8'd0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      clk_prev <= filt[0];
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= 8'd0;
        end else if (fcnt[i] == 8'(FILTER_LEN - 1)) begin
          filt[i] <= sync2[i];
          fcnt[i] <= 8'd0;
        end else begin
          fcnt[i] <= fcnt[i] + 8'd1;
        end
      end
    end
  end

  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par;
  logic [TW-1:0] tmo;
  logic          push_req;
  logic [7:0]    push_byte;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      bit_cnt      <= 3'd0;
      shreg        <= 8'd0;
      par          <= 1'b0;
      tmo          <= '0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
      push_req     <= 1'b0;
      push_byte    <= 8'd0;
    end else begin
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
      push_req     <= 1'b0;
      if (state != IDLE) tmo <= fall ? '0 : tmo + TW'(1);
      case (state)
        IDLE: if (fall && !din) begin
          state   <= DATA;
          bit_cnt <= 3'd0;
          shreg   <= 8'd0;
          tmo     <= '0;
        end
        DATA: if (fall) begin
          shreg   <= {din, shreg[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state <= PARITY;
        end
        PARITY: if (fall) begin
          par   <= din;
          state <= STOP;
        end
        STOP: if (fall) begin
          if (^{shreg, par} == 1'b0) begin
            parity_error <= 1'b1;
          end else if (!din) begin
            frame_error <= 1'b1;
          end else begin
            push_req  <= 1'b1;
            push_byte <= shreg;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // abort a stalled frame once TIMEOUT cycles pass without a clock fall
      if (state != IDLE && !fall && tmo == TW'(TIMEOUT - 1)) begin
        frame_error <= 1'b1;
        state       <= IDLE;
      end
    end
  end

  logic [7:0]       mem [DEPTH];
  logic [FIFO_LOG2:0] wr_ptr, rd_ptr;
  logic             empty, full, pop, do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[FIFO_LOG2] != rd_ptr[FIFO_LOG2]) &&
                   (wr_ptr[FIFO_LOG2-1:0] == rd_ptr[FIFO_LOG2-1:0]);
  assign pop     = data_valid & data_ready;
  assign do_push = push_req & (~full | pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_req && full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !reset) mem[wr_ptr[FIFO_LOG2-1:0]] <= push_byte;
  end

  assign data_valid = ~empty;
  assign data_out   = empty ? 8'd0 : mem[rd_ptr[FIFO_LOG2-1:0]];

endmodule
`default_nettype wire

// File: tb/tb_ps2_receiver.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_ps2_receiver: randomized scoreboard bench for ps2_receiver
// Rev 1.0
// ------------------------------------------------------------------
module tb_ps2_receiver;

  localparam int TMO = 2000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready = 1'b1;
  logic       parity_error, frame_error, overflow;

  ps2_receiver #(.FILTER_LEN(8), .TIMEOUT(TMO), .FIFO_LOG2(2)) dut (
    .clk(clk), .reset(reset), .ps2_clk_in(ps2_clk), .ps2_data_in(ps2_data),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .parity_error(parity_error), .frame_error(frame_error), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int half = 60;
  bit done = 1'b0;
  bit exp_ovf = 1'b0;
  int fifo_q[$];   // bytes the DUT FIFO should currently hold
  int err_q[$];    // expected error pulses: 1 = parity, 2 = frame

  task automatic check(string name, int act, int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic wait_cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(logic b);
    ps2_data = b;
    wait_cyc(half);
    ps2_clk = 1'b0;
    wait_cyc(half);
    ps2_clk = 1'b1;
  endtask

  task automatic model_push(int d);
    if (fifo_q.size() < 4) fifo_q.push_back(d);
    else exp_ovf = 1'b1;
  endtask

  task automatic send_frame(logic [7:0] d, logic bad_par, logic stop);
    logic p;
    p = (~^d) ^ bad_par;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    if ((^{d, p}) == 1'b0) err_q.push_back(1);
    else if (!stop) err_q.push_back(2);
    else model_push(int'(d));
    send_bit(stop);
    ps2_data = 1'b1;
    wait_cyc(3 * half);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    fifo_q.delete();
    err_q.delete();
    exp_ovf = 1'b0;
    wait_cyc(1);
    reset = 1'b0;
    @(negedge clk);
    check("rst_valid", int'(data_valid), 0);
    check("rst_data", int'(data_out), 0);
    check("rst_perr", int'(parity_error), 0);
    check("rst_ferr", int'(frame_error), 0);
    check("rst_ovf", int'(overflow), 0);
    wait_cyc(1);
  endtask

  task automatic drain(string tag);
    int n;
    n = 0;
    while ((fifo_q.size() != 0 || err_q.size() != 0) && n < 400) begin
      wait_cyc(1);
      n++;
    end
    check({tag, "_bytes_left"}, fifo_q.size(), 0);
    check({tag, "_errs_left"}, err_q.size(), 0);
  endtask

  // monitor: compares every handshake and error pulse against the queues
  initial begin
    int got, exp;
    forever begin
      @(negedge clk);
      if (!reset && !done) begin
        if (data_valid && data_ready) begin
          if (fifo_q.size() == 0) check("spurious_byte", int'(data_valid), 0);
          else check("data_out", int'(data_out), fifo_q.pop_front());
        end
        if (parity_error || frame_error) begin
          got = parity_error ? 1 : 2;
          exp = (err_q.size() != 0) ? err_q.pop_front() : 0;
          check("error_pulse", got, exp);
        end
      end
    end
  end

  initial begin
    wait_cyc(4);
    do_reset();

    // single good byte
    send_frame(8'h41, 1'b0, 1'b1);
    drain("single");

    // overflow: five bytes into a four-entry FIFO with no consumer
    data_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_frame(8'(8'h41 + i), 1'b0, 1'b1);
    check("ovf_set", int'(overflow), int'(exp_ovf));
    check("ovf_valid", int'(data_valid), 1);
    data_ready = 1'b1;
    drain("ovf");
    check("ovf_sticky", int'(overflow), int'(exp_ovf));

    // parity error then recovery
    do_reset();
    send_frame(8'h41, 1'b1, 1'b1);
    check("perr_empty", int'(data_valid), 0);
    send_frame(8'h42, 1'b0, 1'b1);
    drain("parity");

    // timeout after four data bits
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    err_q.push_back(2);
    wait_cyc(TMO + 500);
    send_frame(8'h42, 1'b0, 1'b1);
    drain("timeout");

    // short clock glitch in idle with data low, then a bad stop bit
    ps2_data = 1'b0;
    wait_cyc(20);
    ps2_clk = 1'b0;
    wait_cyc(5);
    ps2_clk = 1'b1;
    wait_cyc(50);
    ps2_data = 1'b1;
    wait_cyc(50);
    check("glitch_valid", int'(data_valid), 0);
    send_frame(8'h5A, 1'b0, 1'b0);
    check("stop_err_empty", int'(data_valid), 0);
    drain("glitch");

    // reset in the middle of a frame
    send_bit(1'b0);
    for (int i = 0; i < 6; i++) send_bit(i[0]);
    ps2_data = 1'b1;
    wait_cyc(5);
    do_reset();
    send_frame(8'h1C, 1'b0, 1'b1);
    drain("midreset");

    // randomized frames with occasional parity and stop faults
    for (int k = 0; k < 12; k++) begin
      half = $urandom_range(40, 80);
      send_frame(8'($urandom), ($urandom % 4) == 0, ($urandom % 4) != 0);
    end
    drain("random");
    check("final_ovf", int'(overflow), int'(exp_ovf));

    done = 1'b1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ps2_receiver.md
# ps2_receiver

Receives PS/2 keyboard frames from the bidirectional clock/data pins of the IO header and delivers scan-code bytes to the CPU-side peripheral logic through a valid/ready handshake. It sits between the board IO pads (PS/2 clock and data lines) and the keyboard register block in the system bus. It synchronises and glitch-filters the asynchronous lines, deframes 11-bit frames, checks parity and framing, and buffers bytes in a small FIFO. This block is receive-only and never drives the PS/2 lines.

## Interface
Parameters:
- FILTER_LEN, 8: consecutive identical synchronised samples required before the filtered line changes (1..255).
- TIMEOUT, 20000: cycles without a filtered clock fall mid-frame before the frame is aborted (200 µs at 100 MHz).
- FIFO_LOG2, 2: FIFO depth = 2^FIFO_LOG2 bytes (default 4).

Ports:
- clk  in  1  system clock (100 MHz); the only clock.
- reset  in  1  synchronous, active-high reset.
- ps2_clk_in  in  1  raw PS/2 clock pin (asynchronous).
- ps2_data_in  in  1  raw PS/2 data pin (asynchronous).
- data_out  out  8  FIFO head byte; valid only while data_valid=1.
- data_valid  out  1  FIFO non-empty.
- data_ready  in  1  consumer accepts head byte when data_valid & data_ready.
- parity_error  out  1  one-cycle pulse: frame discarded for bad parity.
- frame_error  out  1  one-cycle pulse: frame discarded for bad stop bit or timeout.
- overflow  out  1  sticky: a good byte was dropped because the FIFO was full. Cleared only by reset.

## Operation
- Input path: each line passes through a 2-FF synchroniser, then a filter. The filtered value takes the synchronised value after FILTER_LEN consecutive identical samples. The filtered reset value is 1. A filtered clock fall is a 1→0 transition of the filtered clock. All sampling uses filtered data at the filtered clock-fall cycle.
- States: IDLE, DATA, PARITY, STOP.
  - IDLE: on clock fall with data=0 (start bit), go to DATA, clear bit counter and shift register. A clock fall with data=1 is ignored.
  - DATA: on each fall, shift data in LSB-first. After the 8th bit, go to PARITY.
  - PARITY: on fall, latch the parity bit and go to STOP.
  - STOP: on fall, check the frame.
    - Odd parity fails (XOR of 8 data bits and the parity bit = 0): pulse parity_error; no push.
    - Otherwise, stop bit = 0: pulse frame_error; no push.
    - Otherwise: push the byte.
    - Always return to IDLE.
- Parity error takes precedence over stop error.
- Timeout: in DATA, PARITY or STOP, a counter resets on every clock fall. If it reaches TIMEOUT, the frame is aborted: pulse frame_error and go to IDLE.
- FIFO: 2^FIFO_LOG2 entries. Push when not full, or when full and a pop occurs in the same cycle. If full with no pop, drop the byte and set overflow. Pointer wrap is modulo depth, with an extra MSB for full/empty.
- data_out is driven from the registered read pointer; there is no push→output bypass.

## Timing
- Reset values:
  - State = IDLE, FIFO empty, filtered lines = 1.
  - data_valid=0, data_out=0, parity_error=0, frame_error=0, overflow=0.
- Raw pin edge to filtered edge: 2 (sync) + FILTER_LEN cycles.
- Filtered stop-bit fall at cycle N:
  - Error pulse (if any) is high in cycle N+1 only.
  - FIFO write occurs at the N+1 edge; data_valid=1 from cycle N+2.
- Pop: data_out and data_valid update the cycle after the accepting handshake.
- Reset asserted mid-frame discards the partial frame and all FIFO contents. After reset, the next start bit is recognised normally.
- Glitches shorter than FILTER_LEN cycles produce no state change.

## Test plan
- Send 0x41 (start 0, bits LSB-first, parity 1, stop 1) with clock halves of 3000 cycles, data_ready=1 → data_valid pulses once with data_out=0x41; no error pulses.
- Send bytes 0x41..0x45 back-to-back with data_ready=0, then raise data_ready → reads 0x41, 0x42, 0x43, 0x44 in order; 0x45 is dropped; overflow=1 and stays 1 until reset.
- Send 0x41 with parity bit 0 → one-cycle parity_error pulse; FIFO stays empty. A following valid 0x42 is received correctly.
- Send start plus 4 data bits, then hold the clock high for 25000 cycles → frame_error pulse at TIMEOUT. A following valid 0x42 yields exactly one byte, 0x42.
- Apply a 5-cycle low glitch on ps2_clk_in in IDLE with data=0 → no state change, no output. Then send 0x5A with the stop bit forced to 0 → frame_error pulse, no push.
- Assert reset for 1 cycle after the 6th data bit of a frame → all outputs return to reset values. The next full frame 0x1C is received as 0x1C.
